// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the 4-digit combination lock.
// State encoding, digit/code sizes, timer width and pulse decoder.
package combo_lock_pkg;

  localparam int DIG_W    = 2;
  localparam int CODE_LEN = 4;
  localparam int TMR_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    OPEN,
    LOCKOUT
  } state_t;

  // Returns {valid, index}; valid only for exactly one bit set.
  function automatic logic [DIG_W:0] decode_pulse(
    input logic [3:0] p
  );
    logic [DIG_W:0] r;
    r = '0;
    case (p)
      4'b0001: r = {1'b1, 2'd0};
      4'b0010: r = {1'b1, 2'd1};
      4'b0100: r = {1'b1, 2'd2};
      4'b1000: r = {1'b1, 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/combo_timer.sv
// Loadable down-counter with zero flag, shared by timeout/open/lockout.
// Ports: Clock, Resetn, load, val -> zero (count == 0).
module combo_timer
  import combo_lock_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             load,
  input  logic [TMR_W-1:0] val,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Combination lock FSM: 4-digit code entry, timeout, open hold, lockout.
// Ports: Clock, Resetn, pulse[3:0] -> unlock, error, locked_out, digit_cnt.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int CODE0       = 2,
  parameter int CODE1       = 0,
  parameter int CODE2       = 3,
  parameter int CODE3       = 1,
  parameter int TIMEOUT_CYC = 16,
  parameter int OPEN_CYC    = 8,
  parameter int LOCKOUT_CYC = 32,
  parameter int MAX_FAIL    = 3
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] pulse,
  output logic       unlock,
  output logic       error,
  output logic       locked_out,
  output logic [2:0] digit_cnt
);

  localparam logic [DIG_W-1:0] C0 = DIG_W'(CODE0);
  localparam logic [DIG_W-1:0] C1 = DIG_W'(CODE1);
  localparam logic [DIG_W-1:0] C2 = DIG_W'(CODE2);
  localparam logic [DIG_W-1:0] C3 = DIG_W'(CODE3);

  localparam logic [TMR_W-1:0] TO_L = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] OP_L = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LO_L = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [2:0]       MF   = 3'(MAX_FAIL);

  localparam logic [CODE_LEN-2:0][DIG_W-1:0] HEAD = {C2, C1, C0};

  state_t state, state_n;

  // Last digit resolves the entry at once, so only the first three are held.
  logic [CODE_LEN-2:0][DIG_W-1:0] digs, digs_n;

  logic       mism, mism_n;
  logic [2:0] fails, fails_n, fails_inc;
  logic [2:0] cnt_n;
  logic       unlock_n, error_n, lock_n;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  logic             ev, valid, hit, ok;
  logic [DIG_W-1:0] idx, want;
  logic [DIG_W:0]   dec;

  combo_timer u_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (tmr_load),
    .val    (tmr_val),
    .zero   (tmr_zero)
  );

  assign ev    = |pulse;
  assign dec   = decode_pulse(pulse);
  assign valid = dec[DIG_W];
  assign idx   = dec[DIG_W-1:0];

  always_comb begin
    want = C0;
    unique case (digit_cnt[1:0])
      2'd0: want = C0;
      2'd1: want = C1;
      2'd2: want = C2;
      2'd3: want = C3;
    endcase
  end

  assign hit = valid && (idx == want);
  assign ok  = !mism && hit && (digs == HEAD);

  assign fails_inc = (fails == MF) ? fails : fails + 3'd1;

  always_comb begin
    state_n  = state;
    digs_n   = digs;
    mism_n   = mism;
    fails_n  = fails;
    cnt_n    = digit_cnt;
    unlock_n = unlock;
    error_n  = 1'b0;
    lock_n   = locked_out;
    tmr_load = 1'b0;
    tmr_val  = TO_L;
    unique case (state)
      IDLE: begin
        if (ev) begin
          digs_n[0] = idx;
          mism_n    = !hit;
          cnt_n     = 3'd1;
          tmr_load  = 1'b1;
          state_n   = ENTRY;
        end
      end
      ENTRY: begin
        if (ev) begin
          tmr_load = 1'b1;
          if (digit_cnt == 3'd3) begin
            cnt_n  = 3'd0;
            mism_n = 1'b0;
            if (ok) begin
              state_n  = OPEN;
              unlock_n = 1'b1;
              fails_n  = 3'd0;
              tmr_val  = OP_L;
            end else begin
              error_n = 1'b1;
              fails_n = fails_inc;
              if (fails_inc == MF) begin
                state_n = LOCKOUT;
                lock_n  = 1'b1;
                tmr_val = LO_L;
              end else begin
                state_n = IDLE;
              end
            end
          end else begin
            digs_n[digit_cnt[1:0]] = idx;
            mism_n = mism | !hit;
            cnt_n  = digit_cnt + 3'd1;
          end
        end else if (tmr_zero) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          mism_n  = 1'b0;
        end
      end
      OPEN: begin
        if (tmr_zero) begin
          state_n  = IDLE;
          unlock_n = 1'b0;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_n = IDLE;
          lock_n  = 1'b0;
          fails_n = 3'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      digs       <= '0;
      mism       <= 1'b0;
      fails      <= 3'd0;
      digit_cnt  <= 3'd0;
      unlock     <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      digs       <= digs_n;
      mism       <= mism_n;
      fails      <= fails_n;
      digit_cnt  <= cnt_n;
      unlock     <= unlock_n;
      error      <= error_n;
      locked_out <= lock_n;
    end
  end

endmodule

// File: doc/combo_lock_fsm.md
COMBO_LOCK_FSM -- requirements
Module: combo_lock_fsm

Interface
REQ-001 Parameter CODE0, default 2, SHALL be the button index of code digit 0 (range 0-3).
REQ-002 Parameter CODE1, default 0, SHALL be the button index of code digit 1.
REQ-003 Parameter CODE2, default 3, SHALL be the button index of code digit 2.
REQ-004 Parameter CODE3, default 1, SHALL be the button index of code digit 3.
REQ-005 Parameter TIMEOUT_CYC, default 16, SHALL be the inactivity limit during entry, in cycles (>=2).
REQ-006 Parameter OPEN_CYC, default 8, SHALL be the unlock hold time, in cycles (>=1).
REQ-007 Parameter LOCKOUT_CYC, default 32, SHALL be the lockout duration, in cycles (>=1).
REQ-008 Parameter MAX_FAIL, default 3, SHALL be the number of consecutive failed entries that triggers lockout (1-7).
REQ-009 Clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-010 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-011 pulse  input  4  SHALL carry one-cycle button pulses, bit i = button i, from the input conditioners.
REQ-012 unlock  output  1  SHALL be high while the lock is open.
REQ-013 error  output  1  SHALL be a one-cycle pulse on each rejected 4-digit entry.
REQ-014 locked_out  output  1  SHALL be high during lockout.
REQ-015 digit_cnt  output  3  SHALL be the number of digits accepted in the current entry (0-4).

Function
REQ-016 The FSM SHALL have states IDLE, ENTRY, OPEN, LOCKOUT, and all outputs SHALL be registered.
REQ-017 A digit event SHALL be any cycle with pulse != 0; exactly one bit set = button index; more than one bit set = invalid digit that never matches.
REQ-018 IDLE: a digit event SHALL store the digit, set digit_cnt=1, and move to ENTRY.
REQ-019 ENTRY: each digit event SHALL store the digit and increment digit_cnt; the mismatch flag SHALL accumulate silently, with no early rejection.
REQ-020 On the 4th digit with all digits matching, the FSM SHALL enter OPEN, with unlock high starting the cycle after the sampling edge, and the fail count cleared.
REQ-021 On the 4th digit with any mismatch, error SHALL pulse for one cycle after the sampling edge, and the fail count SHALL increment.
REQ-022 After a mismatch, if the new fail count equals MAX_FAIL, the FSM SHALL go to LOCKOUT; otherwise it SHALL go to IDLE.
REQ-023 digit_cnt SHALL return to 0 on the cycle unlock, error or LOCKOUT asserts.
REQ-024 ENTRY: TIMEOUT_CYC consecutive cycles without a digit event SHALL discard the entry and return to IDLE with digit_cnt=0, no error, and the fail count unchanged.
REQ-025 Any digit event SHALL reload the inactivity timer.
REQ-026 OPEN SHALL last exactly OPEN_CYC cycles, then return to IDLE; pulses SHALL be ignored in OPEN.
REQ-027 LOCKOUT SHALL last exactly LOCKOUT_CYC cycles, then return to IDLE with the fail count cleared; pulses SHALL be ignored in LOCKOUT.
REQ-028 A digit event on the same cycle the timeout expires SHALL be accepted, and the timeout SHALL be cancelled.
REQ-029 The fail counter SHALL saturate at MAX_FAIL and never wrap.

Reset
REQ-030 Resetn low SHALL immediately force IDLE, unlock=0, error=0, locked_out=0, digit_cnt=0, fail count=0, timer=0, and stored digits=0.
REQ-031 Reset asserted mid-entry, in OPEN or in LOCKOUT SHALL abort that activity with no residual effect after release.
REQ-032 The first digit event SHALL be accepted on the first rising edge after Resetn deasserts.

Structure
REQ-033 Package combo_lock_pkg SHALL hold the state typedef/encoding, the digit width (2), the code length (4) and the timer width constant.
REQ-034 A single sub-module combo_timer SHALL provide one loadable down-counter with a zero flag, shared for timeout, open and lockout.

Verification
REQ-035 Correct code: pulses 4'b0100, 4'b0001, 4'b1000, 4'b0010 with 2-cycle gaps -> unlock high for exactly 8 cycles, then IDLE; error never asserts.
REQ-036 Wrong code: buttons 2,0,3,0 -> error pulses once after the 4th digit, with no error after digits 1-3; digit_cnt goes 1,2,3,0.
REQ-037 Three wrong entries -> the third entry gives error plus locked_out high for 32 cycles; the correct code entered during lockout has no effect; the correct code after lockout -> unlock.
REQ-038 Timeout: buttons 2,0, then 16 idle cycles -> digit_cnt=0, no error; the fail count is unchanged (two further wrong entries do not lock out).
REQ-039 Multi-bit pulse: 4'b0101 as digit 1, followed by the correct remaining digits -> error.
REQ-040 Resetn low for 1 cycle after 3 digits -> all outputs 0; the full correct code afterwards -> unlock.
